// File: rtl/uart_rx_deframer.sv
// UART receive deframer: validates the start bit, samples data LSB-first at mid-bit, checks stop.
// Words leave on a valid/ready port with sticky errors; define UART_RX_PARITY_EN for a parity bit.
module uart_rx_deframer #(
   parameter int OverSample = 8,
   parameter int DataBits   = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_tick,
   input  logic                i_rx,
   input  logic                i_ready,
   input  logic                i_err_clr,
   input  logic                i_parity_odd,
   output logic [DataBits-1:0] o_data,
   output logic                o_valid,
   output logic                o_busy,
   output logic                o_frame_err,
   output logic                o_overrun,
   output logic                o_parity_err
);

   localparam int TW = $clog2(OverSample);
   localparam int BW = (DataBits > 1) ? $clog2(DataBits) : 1;
   localparam logic [TW-1:0] TICK_HALF = TW'(OverSample / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OverSample - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DataBits - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t              r_state;
   logic                r_rx_meta;
   logic                r_rx_s;
   logic [TW-1:0]       r_tick_cnt;
   logic [BW-1:0]       r_bit_cnt;
   logic [DataBits-1:0] r_shift;
   logic                r_done;
   logic                w_tick_last;

   assign w_tick_last = (r_tick_cnt == TICK_LAST);

   // NOTE: the synchroniser resets to the idle-high line level so leaving reset never fakes a start bit.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= i_rx;
         r_rx_s    <= r_rx_meta;
      end
   end

`ifndef UART_RX_PARITY_EN
   logic w_unused_parity_odd;
   assign w_unused_parity_odd = i_parity_odd;
   assign o_parity_err        = 1'b0;
`endif

   // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_tick_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_done      <= 1'b0;
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_busy      <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         o_parity_err <= 1'b0;
`endif
      end else begin
         // NOTE: the clear comes first so any flag set further down wins on the same edge.
         if (i_err_clr) begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
`endif
         end

         // A completed frame is presented one clock after its stop-bit sample.
         r_done <= 1'b0;
         if (r_done) begin
            if (!o_valid || i_ready) begin
               o_data  <= r_shift;
               o_valid <= 1'b1;
            end else begin
               o_overrun <= 1'b1;
            end
         end else if (i_ready) begin
            o_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (!r_rx_s) begin
                  r_state    <= S_START;
                  r_tick_cnt <= '0;
                  o_busy     <= 1'b1;
               end
            end

            S_START: begin
               if (i_tick) begin
                  if (r_tick_cnt == TICK_HALF) begin
                     r_tick_cnt <= '0;
                     if (r_rx_s) begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                     end else begin
                        r_bit_cnt <= '0;
                        r_state   <= S_DATA;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TW'(1);
                  end
               end
            end

            S_DATA: begin
               if (i_tick) begin
                  if (w_tick_last) begin
                     r_tick_cnt <= '0;
                     r_shift    <= {r_rx_s, r_shift[DataBits-1:1]};
                     r_bit_cnt  <= r_bit_cnt + BW'(1);
                     if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        r_state <= S_PARITY;
`else
                        r_state <= S_STOP;
`endif
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TW'(1);
                  end
               end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (i_tick) begin
                  if (w_tick_last) begin
                     r_tick_cnt <= '0;
                     if (r_rx_s != (^r_shift ^ i_parity_odd)) o_parity_err <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TW'(1);
                  end
               end
            end
`endif

            S_STOP: begin
               if (i_tick) begin
                  if (w_tick_last) begin
                     r_tick_cnt <= '0;
                     if (r_rx_s) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                     end else begin
                        o_frame_err <= 1'b1;
                        r_state     <= S_BREAK;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TW'(1);
                  end
               end
            end

            // A line held low after a bad stop bit must not be taken as a new start bit.
            S_BREAK: begin
               if (r_rx_s) begin
                  r_state <= S_IDLE;
                  o_busy  <= 1'b0;
               end
            end

            default: begin
               r_state <= S_IDLE;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
